// File: rtl/downstream_rmw_ctrl.sv
// downstream_rmw_ctrl: serialised read-modify-write sequencer for the per-client cancelled-value RAM
module downstream_rmw_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5,
  parameter int RD_LAT  = 2,
  parameter int WR_TO   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [A_WIDTH-1:0] upd_client,
  input  logic [D_WIDTH-1:0] upd_amount,
  input  logic               clr_valid,
  output logic               clr_ready,
  input  logic [A_WIDTH-1:0] clr_client,
  output logic               clr_rsp_valid,
  output logic [D_WIDTH-1:0] clr_rsp_data,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  input  logic               ram_memwr,
  output logic               busy,
  output logic               sat_pulse,
  output logic               err_timeout
);
  localparam int RW = $clog2(RD_LAT + 1);
  localparam int WW = $clog2(WR_TO + 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;
  state_t             state_q;
  logic               op_q, rr_q, we_q, sat_q, rsp_v_q, err_q;
  logic [A_WIDTH-1:0] client_q;
  logic [D_WIDTH-1:0] amt_q, old_q, wdata_q, rsp_d_q;
  logic [RW-1:0]      rd_cnt_q;
  logic [WW-1:0]      wr_cnt_q;
  logic               idle, pick_upd, pick_clr;
  logic [D_WIDTH:0]   sum_d;
  logic [D_WIDTH-1:0] wr_d;
  // rr_q high means clear was the last tie winner, so update wins the next tie
  assign idle     = state_q == IDLE;
  assign pick_upd = idle & upd_valid & (~clr_valid | rr_q);
  assign pick_clr = idle & clr_valid & (~upd_valid | ~rr_q);
  assign upd_ready = rst_n & idle & ~pick_clr;
  assign clr_ready = rst_n & idle & ~pick_upd;
  assign sum_d = {1'b0, ram_data_read} + {1'b0, amt_q};
  assign wr_d  = op_q ? '0 : (sum_d[D_WIDTH] ? '1 : sum_d[D_WIDTH-1:0]);
  assign ram_address_read  = client_q;
  assign ram_address_write = client_q;
  assign ram_data_write    = wdata_q;
  assign ram_write_enable  = we_q;
  assign busy          = ~idle;
  assign sat_pulse     = sat_q;
  assign err_timeout   = err_q;
  assign clr_rsp_valid = rsp_v_q;
  assign clr_rsp_data  = rsp_d_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      rr_q     <= 1'b1;
      we_q     <= 1'b0;
      sat_q    <= 1'b0;
      rsp_v_q  <= 1'b0;
      err_q    <= 1'b0;
      client_q <= '0;
      amt_q    <= '0;
      old_q    <= '0;
      wdata_q  <= '0;
      rsp_d_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      sat_q   <= 1'b0;
      rsp_v_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_upd | pick_clr) begin
          op_q     <= pick_clr;
          client_q <= pick_clr ? clr_client : upd_client;
          amt_q    <= upd_amount;
          rd_cnt_q <= RW'(RD_LAT - 1);
          state_q  <= RD_WAIT;
          if (upd_valid & clr_valid) rr_q <= pick_clr;
        end
        RD_WAIT: if (rd_cnt_q == '0) begin
          old_q    <= ram_data_read;
          wdata_q  <= wr_d;
          we_q     <= 1'b1;
          sat_q    <= ~op_q & sum_d[D_WIDTH];
          wr_cnt_q <= '0;
          state_q  <= WR;
        end else rd_cnt_q <= rd_cnt_q - 1'b1;
        WR: if (ram_memwr) begin
          we_q    <= 1'b0;
          rsp_v_q <= op_q;
          if (op_q) rsp_d_q <= old_q;
          state_q <= DONE;
        end else if (wr_cnt_q == WW'(WR_TO - 1)) begin
          err_q   <= 1'b1;
          we_q    <= 1'b0;
          state_q <= IDLE;
        end else wr_cnt_q <= wr_cnt_q + 1'b1;
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_downstream_rmw_ctrl.sv
// tb_downstream_rmw_ctrl: directed bench with a transaction-level reference model and a bench-side RAM
module tb_downstream_rmw_ctrl;
  localparam int DW = 16, AW = 5, RD_LAT = 2, WR_TO = 16;
  logic          clk = 0, rst_n = 0;
  logic          upd_valid = 0, clr_valid = 0;
  logic [AW-1:0] upd_client = '0, clr_client = '0;
  logic [DW-1:0] upd_amount = '0;
  logic          upd_ready, clr_ready, clr_rsp_valid, ram_write_enable, ram_memwr, busy, sat_pulse, err_timeout;
  logic [DW-1:0] clr_rsp_data, ram_data_read, ram_data_write;
  logic [AW-1:0] ram_address_read, ram_address_write;

  always #5 clk = ~clk;

  downstream_rmw_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .RD_LAT(RD_LAT), .WR_TO(WR_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_client(upd_client), .upd_amount(upd_amount),
    .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_client(clr_client),
    .clr_rsp_valid(clr_rsp_valid), .clr_rsp_data(clr_rsp_data),
    .ram_address_read(ram_address_read), .ram_data_read(ram_data_read),
    .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
    .ram_write_enable(ram_write_enable), .ram_memwr(ram_memwr),
    .busy(busy), .sat_pulse(sat_pulse), .err_timeout(err_timeout)
  );

  // Bench RAM: registered read, write acknowledged ack_dly cycles after enable rises (-1 = never)
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  logic [DW-1:0] rd_q = '0;
  int            ack_dly = 1, en_cnt = 0;
  logic          pl_en = 0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;
  assign ram_data_read = rd_q;
  assign ram_memwr = ram_write_enable && ack_dly >= 0 && en_cnt == ack_dly;
  always @(posedge clk) begin
    rd_q <= mem[ram_address_read];
    if (pl_en) mem[pl_a] <= pl_d;
    else if (ram_write_enable && ram_memwr) mem[ram_address_write] <= ram_data_write;
    en_cnt <= (ram_write_enable && !ram_memwr) ? en_cnt + 1 : 0;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: one operation at a time; results from arithmetic on a reference copy of the RAM
  logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
  logic          m_busy = 0, m_done = 0, m_op = 0, m_err = 0, m_rr = 1, m_satx = 0, exp_pu, exp_pc;
  logic [AW-1:0] m_cl = '0;
  logic [DW-1:0] m_old = '0, m_new = '0, m_rsp = '0, rsp_last = '0;
  logic [DW:0]   m_sum;
  int            m_wcnt = 0, rsp_cnt = 0, sat_cnt = 0, en_run = 0, en_max = 0;
  logic          any_out;
  assign any_out = |{upd_ready, clr_ready, clr_rsp_valid, clr_rsp_data, ram_address_read, ram_address_write,
                     ram_data_write, ram_write_enable, busy, sat_pulse, err_timeout};

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", any_out, 0);
      m_busy = 0; m_done = 0; m_err = 0; m_rr = 1; m_rsp = '0; m_wcnt = 0;
    end else begin
      exp_pc = !m_busy && clr_valid && (!upd_valid || !m_rr);
      exp_pu = !m_busy && upd_valid && (!clr_valid || m_rr);
      chk("upd_ready", upd_ready, !m_busy && !exp_pc);
      chk("clr_ready", clr_ready, !m_busy && !exp_pu);
      chk("busy", busy, m_busy);
      chk("err_timeout", err_timeout, m_err);
      chk("rsp_valid", clr_rsp_valid, m_done && m_op);
      chk("rsp_data", clr_rsp_data, (m_done && m_op) ? m_old : m_rsp);
      chk("sat_pulse", sat_pulse, ram_write_enable && m_wcnt == 0 && m_satx);
      if (!m_busy || m_done) chk("we_outside_write", ram_write_enable, 0);
      if (m_busy) chk("rd_addr", ram_address_read, m_cl);
      if (ram_write_enable) begin
        chk("wr_addr", ram_address_write, m_cl);
        chk("wr_data", ram_data_write, m_new);
      end
      if (clr_rsp_valid) begin rsp_cnt++; rsp_last = clr_rsp_data; end
      if (sat_pulse) sat_cnt++;
      en_run = ram_write_enable ? en_run + 1 : 0;
      if (en_run > en_max) en_max = en_run;
      if (m_done) begin
        if (m_op) m_rsp = m_old;
        m_done = 0; m_busy = 0;
      end else if (m_busy && ram_write_enable) begin
        if (ram_memwr) begin ref_mem[m_cl] = m_new; m_done = 1; end
        else if (m_wcnt == WR_TO - 1) begin m_err = 1; m_busy = 0; end
        else m_wcnt++;
      end else if (exp_pu || exp_pc) begin
        if (upd_valid && clr_valid) m_rr = exp_pc;
        m_busy = 1; m_op = exp_pc; m_wcnt = 0;
        m_cl   = exp_pc ? clr_client : upd_client;
        m_old  = ref_mem[m_cl];
        m_sum  = {1'b0, m_old} + {1'b0, upd_amount};
        m_satx = !exp_pc && m_sum[DW];
        m_new  = exp_pc ? '0 : (m_satx ? '1 : m_sum[DW-1:0]);
      end
      if (pl_en) ref_mem[pl_a] = pl_d;
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk) #1; pl_en = 1; pl_a = a; pl_d = d;
    @(posedge clk) #1; pl_en = 0;
  endtask

  task automatic req(input bit is_clr, input logic [AW-1:0] c, input logic [DW-1:0] a);
    bit acc = 0;
    @(posedge clk) #1;
    if (is_clr) begin clr_valid = 1; clr_client = c; end
    else begin upd_valid = 1; upd_client = c; upd_amount = a; end
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = is_clr ? clr_ready : upd_ready;
    end
    chk("accept", acc, 1);
    @(posedge clk) #1;
    upd_valid = 0; clr_valid = 0;
    upd_client = ~c; clr_client = ~c; upd_amount = '1;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("reach_idle", idle, 1);
  endtask

  task automatic op(input bit is_clr, input logic [AW-1:0] c, input logic [DW-1:0] a);
    req(is_clr, c, a);
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk) #1; rst_n = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
  endtask

  int r0, s0, ng, lat;
  logic [3:0] order;
  bit got;

  initial begin
    upd_valid = 1;
    repeat (3) @(posedge clk);
    #1; chk("reset_ready_gated", upd_ready, 0);
    upd_valid = 0; rst_n = 1;

    op(0, 3, 100);
    op(0, 3, 50);
    r0 = rsp_cnt;
    op(1, 3, 0);
    chk("clr_after_two_upd", rsp_last, 150);
    chk("clr_single_pulse", rsp_cnt - r0, 1);
    op(1, 3, 0);
    chk("second_clr_zero", rsp_last, 0);
    chk("ram3_cleared", mem[3], 0);

    preload(7, 16'hFFF0);
    s0 = sat_cnt;
    op(0, 7, 16'h0020);
    chk("sat_value", mem[7], 16'hFFFF);
    chk("sat_pulses_1", sat_cnt - s0, 1);
    op(0, 7, 16'h0001);
    chk("sat_hold", mem[7], 16'hFFFF);
    chk("sat_pulses_2", sat_cnt - s0, 2);

    do_reset();
    @(posedge clk) #1;
    upd_valid = 1; upd_client = 1; upd_amount = 10; clr_valid = 1; clr_client = 2;
    ng = 0; order = '0;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      @(negedge clk);
      if (upd_ready) begin order[ng] = 1'b0; ng++; end
      else if (clr_ready) begin order[ng] = 1'b1; ng++; end
    end
    @(posedge clk) #1; upd_valid = 0; clr_valid = 0;
    wait_idle();
    chk("grant_count", ng, 4);
    chk("grant_order", order, 4'b1010);
    chk("tie_upd_accum", mem[1], 20);
    chk("tie_clr_rsp", rsp_last, 0);

    ack_dly = -1; en_max = 0;
    op(0, 4, 5);
    chk("timeout_we_cycles", en_max, WR_TO);
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_no_commit", mem[4], 0);
    ack_dly = 1;
    op(0, 4, 5);
    chk("after_timeout_commit", mem[4], 5);
    chk("timeout_sticky", err_timeout, 1);

    preload(9, 77);
    req(1, 9, 0);
    r0 = rsp_cnt;
    rst_n = 0;
    #1; chk("mid_reset_outputs", any_out, 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1;
    chk("mid_reset_no_rsp", rsp_cnt - r0, 0);
    op(1, 9, 0);
    chk("after_reset_clr", rsp_last, 77);

    ack_dly = 4;
    preload(5, 16'h1234);
    @(posedge clk) #1; clr_valid = 1; clr_client = 5;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = clr_ready;
    end
    chk("lat_accept", got, 1);
    lat = 1; got = 0;
    @(posedge clk) #1; clr_valid = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = clr_rsp_valid;
    end
    chk("lat_rsp_seen", got, 1);
    chk("lat_cycles", lat, 1 + RD_LAT + 5 + 1);
    chk("lat_rsp_data", clr_rsp_data, 16'h1234);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/downstream_rmw_ctrl.md
Name: downstream_rmw_ctrl

Overview:
- Sequences read-modify-write access to the per-client downstream RAM. The RAM holds accumulated cancelled-order value, indexed by clientID.
- Arbitrates between two requesters:
  - update port: accumulates a cancelled amount into a client entry.
  - clear port: reads a client entry, returns it, and zeroes it.
- Serialises every operation, so no same-address read/write hazard can occur.
- Sits between order-cancel processing and the RAM. Drives both RAM ports from one clock; the RAM's clk_write and clk_read are tied to clk.

Parameters:
- D_WIDTH, 16, data width of RAM entries and amounts
- A_WIDTH, 5, clientID / RAM address width
- RD_LAT, 2, cycles from driving the RAM read address to valid read data
- WR_TO, 16, maximum cycles to wait for memwr before declaring a write timeout

Ports:
- clk  in  1  single clock for controller and RAM
- rst_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted when upd_valid&&upd_ready
- upd_client  in  A_WIDTH  clientID to update
- upd_amount  in  D_WIDTH  cancelled amount to add
- clr_valid  in  1  read-and-clear request
- clr_ready  out  1  clear accepted when clr_valid&&clr_ready
- clr_client  in  A_WIDTH  clientID to read and clear
- clr_rsp_valid  out  1  one-cycle pulse: clr_rsp_data is valid
- clr_rsp_data  out  D_WIDTH  pre-clear value of the cleared entry
- ram_address_read  out  A_WIDTH  RAM read address
- ram_data_read  in  D_WIDTH  RAM read data
- ram_address_write  out  A_WIDTH  RAM write address
- ram_data_write  out  D_WIDTH  RAM write data
- ram_write_enable  out  1  RAM write enable
- ram_memwr  in  1  RAM write-done indication
- busy  out  1  high whenever the FSM is not in IDLE
- sat_pulse  out  1  one-cycle pulse: an update saturated
- err_timeout  out  1  sticky flag: a write was not acknowledged

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; every output 0; rr_last=CLR, so an update wins the first tie.
- Reset asserted mid-operation aborts the operation. The RAM entry keeps whatever was last committed. No response is issued.
- FSM states: IDLE, RD_WAIT, WR, DONE.
- IDLE:
  - upd_ready=clr_ready=1 only in IDLE and only when the other port is not being granted this cycle.
  - Arbitration:
    - One valid: that port is granted.
    - Both valid: grant the port not in rr_last; update rr_last.
  - On grant:
    - Latch op, client and amount.
    - Drive ram_address_read=client.
    - Load rd_cnt=RD_LAT-1 and go to RD_WAIT.
- RD_WAIT:
  - Hold ram_address_read.
  - Decrement rd_cnt each cycle. At rd_cnt==0, capture ram_data_read as old and go to WR.
- WR, new value:
  - Update: new=old+amount, computed at D_WIDTH+1 bits. If the carry bit is set, new=all-ones and sat_pulse=1 for one cycle. No wrap-around.
  - Clear: new=0.
- WR, RAM drive and exit:
  - Drive ram_address_write=client, ram_data_write=new, ram_write_enable=1.
  - Hold these while counting wr_cnt from 0.
  - ram_memwr=1: drop ram_write_enable the next cycle and go to DONE.
  - wr_cnt reaches WR_TO-1 without ram_memwr: set err_timeout (sticky until reset), drop ram_write_enable and go to IDLE. No clear response is issued.
- DONE:
  - If op=clear: clr_rsp_valid=1 and clr_rsp_data=old for exactly this cycle.
  - Go to IDLE. clr_rsp_data holds its value until the next clear response.
- Latency:
  - Minimum accept-to-IDLE is 1+RD_LAT+write-ack cycles+1.
  - The next grant can occur in the cycle after DONE.
- Back-to-back updates to the same client accumulate correctly because operations are serialised.
- A requester may drop valid before a grant without side effect. Latched fields ignore input changes after the grant.
- Address wrap: client is A_WIDTH bits. No bounds check is needed.

Test Plan:
- Read-and-clear after two updates: upd(client 3, 100), then upd(client 3, 50), then clr(client 3) -> clr_rsp_data=150 on a single clr_rsp_valid pulse. A following clr(client 3) returns 0.
- Saturating update: preload client 7=0xFFF0, then upd(client 7, 0x0020) -> RAM entry=0xFFFF, one sat_pulse. A further upd(client 7, 1) stays at 0xFFFF and pulses sat_pulse again.
- Simultaneous requests: upd_valid and clr_valid held high, upd on client 1 amount 10, clr on client 2 -> grants alternate upd, clr, upd, clr, with upd first after reset. ready is never high on both ports in the same cycle.
- Write timeout: ram_memwr tied 0, issue upd(client 4, 5) -> ram_write_enable high for exactly WR_TO cycles. err_timeout=1 and stays 1. The FSM returns to IDLE and a later request is granted.
- Reset mid-operation: assert rst_n=0 during RD_WAIT of clr(client 9, entry=77) -> all outputs 0 immediately and no clr_rsp_valid. After release, clr(client 9) returns 77.
- Latency check with RD_LAT=2 and memwr returned 4 cycles after enable -> clr_rsp_valid occurs exactly 1+2+5+1 cycles after the accept edge.
